// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF and MEM pipeline stages, the shared
// memory and the arbiter that sits between them.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// sequencing each access IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [STV_W-1:0]  starve_cnt, starve_n;
  logic              owner_dm, owner_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              pick_if;
  logic              access;
  logic              if_rvalid, dm_rvalid;

  // DM (older instruction) wins ties unless IF has been passed over too often
  assign pick_if = bus.if_req && (!bus.dm_req || (starve_cnt == STV_MAX));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    starve_n = starve_cnt;
    owner_n  = owner_dm;
    we_n     = we_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    rdata_n  = rdata_q;
    case (state)
      IDLE: begin
        if (!bus.if_req) starve_n = '0;
        if (bus.if_req || bus.dm_req) begin
          state_n = ACCESS;
          cnt_n   = '0;
          if (pick_if) begin
            owner_n  = 1'b0;
            we_n     = 1'b0;
            addr_n   = bus.if_addr;
            wdata_n  = '0;
            starve_n = '0;
          end else begin
            owner_n = 1'b1;
            we_n    = bus.dm_we;
            addr_n  = bus.dm_addr;
            wdata_n = bus.dm_wdata;
            if (bus.if_req && (starve_cnt != STV_MAX)) starve_n = starve_cnt + STV_ONE;
          end
        end
      end
      ACCESS: begin
        if (cnt == CNT_LAST) begin
          state_n = RESP;
          if (!we_q) rdata_n = bus.mem_rdata;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      starve_cnt <= starve_n;
      owner_dm   <= owner_n;
      we_q       <= we_n;
      rdata_q    <= rdata_n;
    end
  end

  // Latched access operands are only observed while in ACCESS, so no reset
  always_ff @(posedge clock) begin
    addr_q  <= addr_n;
    wdata_q <= wdata_n;
  end

  assign access    = (state == ACCESS);
  assign if_rvalid = (state == RESP) && !owner_dm;
  assign dm_rvalid = (state == RESP) &&  owner_dm;

  assign bus.mem_en    = access;
  assign bus.mem_we    = access && we_q;
  assign bus.mem_addr  = access ? addr_q  : '0;
  assign bus.mem_wdata = access ? wdata_q : '0;

  assign bus.if_gnt    = access && (cnt == '0) && !owner_dm;
  assign bus.dm_gnt    = access && (cnt == '0) &&  owner_dm;
  assign bus.if_rvalid = if_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.if_rdata  = rdata_q;
  assign bus.dm_rdata  = rdata_q;

  assign bus.stall_if  = bus.if_req && !if_rvalid;
  assign bus.stall_mem = bus.dm_req && !dm_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-exact checks plus a response
// scoreboard fed at request time and drained on every rvalid pulse.
module tb_mem_port_arbiter;
  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] wr_data [256];
  bit          wr_vld  [256];

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00A00093;
      32'h14:  return 32'h00B00113;
      32'h18:  return 32'h22220000;
      32'h40:  return 32'h11110000;
      32'h200: return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: fixed contents overlaid with whatever has been stored
  always_comb begin
    bus.mem_rdata = wr_vld[bus.mem_addr[9:2]] ? wr_data[bus.mem_addr[9:2]] : rom(bus.mem_addr);
  end

  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) begin
      wr_data[bus.mem_addr[9:2]] <= bus.mem_wdata;
      wr_vld[bus.mem_addr[9:2]]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.if_gnt || bus.dm_gnt) chk("one_gnt", 32'(bus.if_gnt && bus.dm_gnt), 0);
    if (bus.if_rvalid || bus.dm_rvalid) begin
      chk("one_rvalid", 32'(bus.if_rvalid && bus.dm_rvalid), 0);
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_extra: observed rvalid with empty queue, expected none");
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_port", 32'(bus.dm_rvalid), 32'(e.dm));
        chk("sb_data", bus.dm_rvalid ? bus.dm_rdata : bus.if_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input bit dm, input logic [31:0] d);
    exp_t e;
    e.dm   = dm;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_rv(input bit dm, input string tag);
    int n = 0;
    while (!(dm ? bus.dm_rvalid : bus.if_rvalid) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 20), 1);
  endtask

  initial begin
    bit exp_dm [10];
    int starve;
    int n;

    // ---- 1: reset held with both requests pending
    reset        = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'h0;
    push(1'b1, 32'h11110000);
    push(1'b0, 32'h00A00093);
    tick();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_gnt", 32'({bus.if_gnt, bus.dm_gnt}), 0);
    chk("rst_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 0);
    tick();
    chk("rst_mem_en2", 32'(bus.mem_en), 0);
    chk("rst_rdata", bus.dm_rdata, 0);
    reset = 1'b0;
    #1;
    chk("rel_idle", 32'(bus.mem_en), 0);
    tick();
    chk("rel_dm_gnt", 32'(bus.dm_gnt), 1);
    chk("rel_if_gnt", 32'(bus.if_gnt), 0);
    wait_rv(1'b1, "t1_dm_timeout");
    bus.dm_req = 1'b0;
    tick();
    wait_rv(1'b0, "t1_if_timeout");
    bus.if_req = 1'b0;
    tick();
    tick();

    // ---- 2: IF fetch alone, cycle-exact
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    push(1'b0, 32'h00A00093);
    #1;
    chk("t2_c0_stall", 32'(bus.stall_if), 1);
    chk("t2_c0_mem_en", 32'(bus.mem_en), 0);
    tick();
    chk("t2_c1_gnt", 32'(bus.if_gnt), 1);
    chk("t2_c1_mem_en", 32'(bus.mem_en), 1);
    chk("t2_c1_addr", bus.mem_addr, 32'h10);
    chk("t2_c1_we", 32'(bus.mem_we), 0);
    chk("t2_c1_stall", 32'(bus.stall_if), 1);
    tick();
    chk("t2_c2_gnt", 32'(bus.if_gnt), 0);
    chk("t2_c2_mem_en", 32'(bus.mem_en), 1);
    chk("t2_c2_stall", 32'(bus.stall_if), 1);
    tick();
    chk("t2_c3_rvalid", 32'(bus.if_rvalid), 1);
    chk("t2_c3_rdata", bus.if_rdata, 32'h00A00093);
    chk("t2_c3_mem_en", 32'(bus.mem_en), 0);
    chk("t2_c3_stall", 32'(bus.stall_if), 0);
    bus.if_req = 1'b0;
    tick();
    chk("t2_c4_rvalid", 32'(bus.if_rvalid), 0);
    tick();

    // ---- 3: simultaneous store and fetch; DM goes first
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h100;
    bus.dm_wdata = 32'hDEADBEEF;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h14;
    push(1'b1, 32'h00A00093);
    push(1'b0, 32'h00B00113);
    tick();
    chk("t3_c1_dm_gnt", 32'(bus.dm_gnt), 1);
    chk("t3_c1_if_gnt", 32'(bus.if_gnt), 0);
    chk("t3_c1_we", 32'(bus.mem_we), 1);
    chk("t3_c1_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t3_c1_addr", bus.mem_addr, 32'h100);
    tick();
    chk("t3_c2_we", 32'(bus.mem_we), 1);
    chk("t3_c2_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    chk("t3_c3_dm_rvalid", 32'(bus.dm_rvalid), 1);
    chk("t3_c3_stall_if", 32'(bus.stall_if), 1);
    bus.dm_req = 1'b0;
    tick();
    chk("t3_c4_idle", 32'(bus.mem_en), 0);
    tick();
    chk("t3_c5_if_gnt", 32'(bus.if_gnt), 1);
    chk("t3_c5_addr", bus.mem_addr, 32'h14);
    wait_rv(1'b0, "t3_if_timeout");
    bus.if_req = 1'b0;
    tick();
    tick();

    // ---- 4: both held continuously; starvation guard forces IF through
    starve = 0;
    for (int g = 0; g < 10; g++) begin
      if (starve == 4) begin
        exp_dm[g] = 1'b0;
        starve    = 0;
      end else begin
        exp_dm[g] = 1'b1;
        starve++;
      end
      push(exp_dm[g], exp_dm[g] ? 32'h11110000 : 32'h22220000);
    end
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h40;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h18;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!(bus.if_gnt || bus.dm_gnt) && n < 12) begin
        tick();
        n++;
      end
      chk($sformatf("t4_gnt_timeout_%0d", g), 32'(n < 12), 1);
      chk($sformatf("t4_order_%0d", g), 32'(bus.dm_gnt), 32'(exp_dm[g]));
      if (g == 9) bus.dm_req = 1'b0;
      tick();
    end
    wait_rv(1'b0, "t4_if_timeout");
    bus.if_req = 1'b0;
    tick();
    tick();

    // ---- 5: reset during the second ACCESS cycle of a DM load
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h200;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    tick();
    chk("t5_dm_gnt", 32'(bus.dm_gnt), 1);
    chk("t5_starve_pre", 32'(dut.starve_cnt), 1);
    tick();
    chk("t5_mem_en_pre", 32'(bus.mem_en), 1);
    reset = 1'b1;
    tick();
    chk("t5_mem_en", 32'(bus.mem_en), 0);
    chk("t5_dm_rvalid", 32'(bus.dm_rvalid), 0);
    chk("t5_starve", 32'(dut.starve_cnt), 0);
    chk("t5_state", 32'(dut.state), 0);
    chk("t5_rdata", bus.dm_rdata, 0);
    bus.dm_req = 1'b0;
    bus.if_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t5_after_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 0);
    tick();

    // ---- 6: load then back-to-back store; read data held across the store
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h200;
    push(1'b1, 32'h12345678);
    push(1'b1, 32'h12345678);
    wait_rv(1'b1, "t6_ld_timeout");
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h204;
    bus.dm_wdata = 32'hCAFEF00D;
    tick();
    wait_rv(1'b1, "t6_st_timeout");
    bus.dm_req = 1'b0;
    tick();
    chk("t6_rdata_hold", bus.dm_rdata, 32'h12345678);
    push(1'b1, 32'hCAFEF00D);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h204;
    tick();
    wait_rv(1'b1, "t6_rd_timeout");
    bus.dm_req = 1'b0;
    tick();
    tick();

    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
